// File: rtl/arb8_rr_sel_if.sv
// Request/grant bundle between requesters and the round-robin mux-select arbiter.
// The master side is the arbiter, which drives grant, select and status.
interface arb8_rr_sel_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       ovf;

  modport master (input req, output gnt, output sel, output busy, output ovf);
  modport slave  (output req, input gnt, input sel, input busy, input ovf);
endinterface

// File: rtl/arb8_rr_sel.sv
// 8-way round-robin arbiter driving the select of a shared 8:1 word mux.
// One-cycle grant latency, idle turnaround between owners, optional hold-time limit.
module arb8_rr_sel #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  arb8_rr_sel_if.master bus
);

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);
  localparam bit         LP_LIMIT_EN = (MAX_HOLD != 0);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_ptr, w_ptr_nx;
  logic [2:0] r_owner, w_owner_nx;
  logic [7:0] r_hold_cnt, w_hold_cnt_nx;
  logic [7:0] r_gnt, w_gnt_nx;
  logic [2:0] r_sel, w_sel_nx;
  logic       r_busy, w_busy_nx;
  logic       r_ovf, w_ovf_nx;

  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_idx;

  // Scan from the farthest slot down so the nearest requester to ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      w_idx = r_ptr + 3'(k);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_ptr_nx      = r_ptr;
    w_owner_nx    = r_owner;
    w_hold_cnt_nx = r_hold_cnt;
    w_gnt_nx      = r_gnt;
    w_sel_nx      = r_sel;
    w_busy_nx     = r_busy;
    w_ovf_nx      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nx  = 8'h00;
        w_busy_nx = 1'b0;
        if (w_found) begin
          w_state_nx    = ST_GRANT;
          w_owner_nx    = w_pick;
          w_sel_nx      = w_pick;
          w_gnt_nx      = 8'h01 << w_pick;
          w_busy_nx     = 1'b1;
          w_hold_cnt_nx = 8'd1;
          w_ptr_nx      = w_pick + 3'd1;
        end
      end
      ST_GRANT: begin
        if (!bus.req[r_owner]) begin
          w_state_nx = ST_IDLE;
          w_gnt_nx   = 8'h00;
          w_busy_nx  = 1'b0;
        end else if (LP_LIMIT_EN && (r_hold_cnt == LP_MAX_HOLD)) begin
          w_state_nx = ST_IDLE;
          w_gnt_nx   = 8'h00;
          w_busy_nx  = 1'b0;
          w_ovf_nx   = 1'b1;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_cnt_nx = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_gnt_nx   = 8'h00;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_owner    <= 3'd0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= 8'h00;
      r_sel      <= 3'd0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_owner    <= w_owner_nx;
      r_hold_cnt <= w_hold_cnt_nx;
      r_gnt      <= w_gnt_nx;
      r_sel      <= w_sel_nx;
      r_busy     <= w_busy_nx;
      r_ovf      <= w_ovf_nx;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;
  assign bus.ovf  = r_ovf;

endmodule

// File: doc/arb8_rr_sel.md
# arb8_rr_sel

Round-robin arbiter that shares one 32-bit datapath resource among up to eight requesters by driving the 3-bit select of the 8:1 32-bit word mux in front of it. It accepts per-requester request lines, issues a registered one-hot grant, and drives the matching mux select. It forces a release after a bounded hold time and inserts one idle turnaround cycle between ownerships. It sits between the requesting units (e.g. memory-port clients, writeback sources) and the shared mux/consumer.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles per ownership. Legal values are 1..255; 0 disables the limit.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  8  request lines; req[i] high means requester i wants the resource
- gnt  out 8  one-hot grant, registered; all-zero when no owner
- sel  out 3  mux select (index of current/last owner), registered
- busy out 1  high while a grant is active (gnt != 0)
- ovf  out 1  one-cycle pulse: grant was revoked by hold-limit expiry

## Operation
- States: IDLE, GRANT. Reset state is IDLE.
- Internal state: ptr[2:0] (priority pointer, reset 0), owner[2:0], hold_cnt[7:0].
- IDLE: if req != 0 at a rising edge, pick the first i with req[i]=1, searching ptr, ptr+1, … mod 8. On that edge:
  - owner=i, sel=i, gnt=1<<i, busy=1, hold_cnt=1
  - ptr=(i+1) mod 8
  - go to GRANT
- IDLE with req == 0: stay in IDLE. gnt=0, busy=0, sel holds its last value.
- GRANT, at each edge:
  - If req[owner]=0: release. Go to IDLE, gnt=0, busy=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD: forced release. Go to IDLE, gnt=0, busy=0, ovf=1 for exactly one cycle.
  - Else: stay in GRANT, hold_cnt+1 (saturating at 255).
- Requests from non-owners never affect the current grant. There is no preemption except hold expiry.
- Because ptr has already advanced, an expired owner that still requests ranks last on the next arbitration. It is re-granted only if no other requester is high.
- sel changes only on a new grant. The consumer must qualify the mux output with busy/gnt.
- ovf is 0 in every cycle except the one following a forced release.

## Timing
- Reset (async): immediately gnt=0, sel=0, busy=0, ovf=0, ptr=0, hold_cnt=0, state=IDLE. This applies mid-grant as well. The first arbitration after rst deasserts gives requester 0 highest priority.
- Grant latency: req sampled high at edge N in IDLE gives gnt/sel valid after edge N (one cycle).
- Release latency: owner's req sampled low at edge M gives gnt=0 after edge M.
- Turnaround: at least one idle cycle (gnt=0) between any two ownerships, including re-grant to the same requester.
- Hold limit: with req held continuously, gnt is high for exactly MAX_HOLD cycles, followed by 1 idle cycle with ovf=1.
- Back-to-back: req drop and a new req in the same cycle means release now, new grant on the next edge.
- All outputs are registered. There is no combinational path from req to any output.
- Maximum grant rate: one new grant every 2 cycles.

## Test plan
- Reset/priority: assert rst mid-grant, then drop it with req=8'hFF. Expect gnt=0, sel=0 asynchronously. First grant is gnt=8'h01, sel=0, one cycle after the first sampling edge.
- Round-robin rotation: req=8'hFF, each owner drops its req for 1 cycle after 3 cycles of grant and then re-raises it. Expect grant order 0,1,…,7,0, with one gnt=0 cycle between each.
- Sparse wrap: ptr=6 (after granting 5), req=8'b0000_0101. Expect grant to 0, then to 2 after release. Requester 0 is not re-granted while 2 waits.
- Hold limit: MAX_HOLD=4, req=8'b0000_0011 held constantly. Expect gnt=01 for 4 cycles, then idle+ovf=1, then gnt=02 for 4 cycles, then idle+ovf, then gnt=01.
- Sole requester expiry: MAX_HOLD=4, req=8'h08 constant. Expect pattern gnt=08 ×4, 00 (ovf=1), repeating. sel=3 throughout.
- Unlimited hold: MAX_HOLD=0, req[2] held for 300 cycles while req[5] is high. Expect gnt=04 for all 300 cycles with no ovf. After req[2] drops: one idle cycle, then gnt=20, sel=5.
